// File: rtl/bsg_tanh_postproc.sv
// Post-processing stage for the tanh divider. It rounds the Q(in_frac_p) quotient to
// Q(out_frac_p), clamps the result to +/-1.0, and buffers it in a 2-entry FIFO.
module bsg_tanh_postproc #(
  parameter int in_width_p  = 32,
  parameter int in_frac_p   = 16,
  parameter int out_width_p = 16,
  parameter int out_frac_p  = 14,
  parameter int cnt_width_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   v_i,
  input  logic [in_width_p-1:0]  data_i,
  output logic                   ready_o,
  output logic                   v_o,
  output logic [out_width_p-1:0] data_o,
  output logic                   sat_o,
  input  logic                   yumi_i,
  output logic [cnt_width_p-1:0] count_o
);

  localparam int shift_lp = in_frac_p - out_frac_p;
  localparam int sum_w_lp = in_width_p + 1;
  localparam int ent_w_lp = out_width_p + 1;

  localparam logic [sum_w_lp-1:0] half_lp =
    {{(sum_w_lp-1){1'b0}}, 1'b1} << (shift_lp - 1);
  localparam logic signed [sum_w_lp-1:0] pos_lim_lp =
    {{(sum_w_lp-1){1'b0}}, 1'b1} << out_frac_p;
  localparam logic signed [sum_w_lp-1:0] neg_lim_lp = -pos_lim_lp;

  // Sign-extend by one bit before adding the rounding constant so that the
  // most positive input cannot wrap negative.
  logic [sum_w_lp-1:0]        sum;
  logic signed [sum_w_lp-1:0] rounded;
  logic signed [sum_w_lp-1:0] clamped;
  logic                       enq_sat;
  logic [ent_w_lp-1:0]        enq_entry;

  assign sum     = {data_i[in_width_p-1], data_i} + half_lp;
  assign rounded = $signed(sum) >>> shift_lp;

  always_comb begin
    clamped = rounded;
    enq_sat = 1'b0;
    if (rounded > pos_lim_lp) begin
      clamped = pos_lim_lp;
      enq_sat = 1'b1;
    end else if (rounded < neg_lim_lp) begin
      clamped = neg_lim_lp;
      enq_sat = 1'b1;
    end
  end

  assign enq_entry = {clamped[out_width_p-1:0], enq_sat};

  logic [1:0]             occ_reg;
  logic [1:0]             occ_next;
  logic                   wr_ptr_reg;
  logic                   rd_ptr_reg;
  logic                   ready_reg;
  logic [cnt_width_p-1:0] count_reg;
  logic                   enq;
  logic                   deq;
  logic [ent_w_lp-1:0]    entry_q [2];
  logic [ent_w_lp-1:0]    head;

  assign enq = v_i & ready_reg;
  assign deq = yumi_i & v_o;

  always_comb begin
    occ_next = occ_reg;
    if (enq && !deq)      occ_next = occ_reg + 2'd1;
    else if (!enq && deq) occ_next = occ_reg - 2'd1;
  end

  // ready is registered from the next occupancy: it stays low through reset,
  // rises on the first clock afterwards, and never depends on yumi_i combinationally.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      occ_reg    <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      ready_reg  <= 1'b0;
      count_reg  <= '0;
    end else begin
      occ_reg   <= occ_next;
      ready_reg <= (occ_next != 2'd2);
      if (enq) wr_ptr_reg <= ~wr_ptr_reg;
      if (deq) begin
        rd_ptr_reg <= ~rd_ptr_reg;
        count_reg  <= count_reg + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [ent_w_lp-1:0] entry_reg;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        entry_reg <= '0;
      end else if (enq && (wr_ptr_reg == 1'(gi))) begin
        entry_reg <= enq_entry;
      end
    end

    assign entry_q[gi] = entry_reg;
  end

  assign head    = entry_q[rd_ptr_reg];
  assign ready_o = ready_reg;
  assign v_o     = (occ_reg != 2'd0);
  assign data_o  = head[ent_w_lp-1:1];
  assign sat_o   = head[0];
  assign count_o = count_reg;

endmodule

// File: tb/tb_bsg_tanh_postproc.sv
// Self-checking bench for bsg_tanh_postproc. It uses directed cases with literal
// expectations, then random traffic checked every cycle against a queue model.
module tb_bsg_tanh_postproc;

  localparam int IW = 32;
  localparam int IF = 16;
  localparam int OW = 16;
  localparam int OF = 14;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          v_i = 1'b0;
  logic [IW-1:0] data_i = '0;
  logic          yumi_i = 1'b0;
  logic          ready_o;
  logic          v_o;
  logic [OW-1:0] data_o;
  logic          sat_o;
  logic [CW-1:0] count_o;

  always #5 clk = ~clk;

  bsg_tanh_postproc #(
    .in_width_p(IW), .in_frac_p(IF), .out_width_p(OW),
    .out_frac_p(OF), .cnt_width_p(CW)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .data_i(data_i),
    .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .sat_o(sat_o),
    .yumi_i(yumi_i), .count_o(count_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: queued {value, sat}, delivered count, and whether ready is expected.
  logic [OW:0] q [$];
  int          m_count = 0;
  bit          m_ready = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round half up to Q14, then clamp to +/-1.0, using plain 64-bit arithmetic.
  function automatic logic [OW:0] model_out(input logic [IW-1:0] d);
    longint x;
    longint r;
    longint lim;
    x   = longint'($signed(d));
    lim = longint'(1) <<< OF;
    r   = (x + (longint'(1) <<< (IF - OF - 1))) >>> (IF - OF);
    if (r > lim)  return {OW'(lim), 1'b1};
    if (r < -lim) return {OW'(-lim), 1'b1};
    return {OW'(r), 1'b0};
  endfunction

  task automatic compare();
    logic [OW:0] h;
    chk("ready_o", longint'(ready_o), longint'(m_ready));
    chk("v_o", longint'(v_o), longint'(q.size() > 0));
    if (q.size() > 0) begin
      h = q[0];
      chk("data_o", longint'(data_o), longint'(h[OW:1]));
      chk("sat_o", longint'(sat_o), longint'(h[0]));
    end
    chk("count_o", longint'(count_o), longint'(m_count));
  endtask

  // Drive one cycle of inputs, advance the model at the clock edge, and check on the falling edge.
  task automatic tick(input bit v, input logic [IW-1:0] d, input bit y);
    bit acc;
    bit deq;
    v_i    = v;
    data_i = d;
    yumi_i = y;
    @(posedge clk);
    acc = v && m_ready;
    deq = y && (q.size() > 0);
    if (deq) begin
      void'(q.pop_front());
      m_count = (m_count + 1) % (1 << CW);
    end
    if (acc) q.push_back(model_out(d));
    m_ready = (q.size() < 2);
    @(negedge clk);
    $display("tick v=%0b d=%08h y=%0b -> ready=%0b v_o=%0b data=%04h sat=%0b cnt=%0d",
             v, d, y, ready_o, v_o, data_o, sat_o, count_o);
    compare();
  endtask

  task automatic model_reset();
    q.delete();
    m_count = 0;
    m_ready = 1'b0;
  endtask

  task automatic chk_lit(input string name, input bit v, input logic [OW-1:0] d, input bit s);
    chk({name, "_v"}, longint'(v_o), longint'(v));
    if (v) begin
      chk({name, "_data"}, longint'(data_o), longint'(d));
      chk({name, "_sat"}, longint'(sat_o), longint'(s));
    end
  endtask

  function automatic logic [IW-1:0] rand_data();
    logic [IW-1:0] r;
    case ($urandom_range(0, 3))
      0:       r = $urandom;
      1:       r = IW'($urandom_range(0, 32'h28000)) - 32'h14000;
      2:       r = ($urandom & 32'h0000_FFFF) | 32'h0000_0002;
      default: r = (($urandom & 32'h0001_0000) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    endcase
    return r;
  endfunction

  initial begin
    int c0;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", longint'(ready_o), 0);
    chk("rst_v", longint'(v_o), 0);
    chk("rst_data", longint'(data_o), 0);
    chk("rst_sat", longint'(sat_o), 0);
    chk("rst_count", longint'(count_o), 0);
    reset_n = 1'b1;
    model_reset();
    #1 compare();
    tick(0, '0, 0);
    chk("ready_after_rst", longint'(ready_o), 1);

    // 0.5 into an empty FIFO: visible exactly one cycle later
    chk_lit("pre_half", 1'b0, '0, 1'b0);
    tick(1, 32'h0000_8000, 1);
    chk_lit("half", 1'b1, 16'h2000, 1'b0);

    // Clamp cases, each entering at occupancy 1 with a simultaneous dequeue
    tick(1, 32'h0001_0000, 1);
    chk_lit("one", 1'b1, 16'h4000, 1'b0);
    tick(1, 32'h0001_2000, 1);
    chk_lit("pos_clamp", 1'b1, 16'h4000, 1'b1);
    tick(1, 32'hFFFE_8000, 1);
    chk_lit("neg_clamp", 1'b1, 16'hC000, 1'b1);

    // Rounding cases
    tick(1, 32'h0000_0002, 1);
    chk_lit("rnd_tie_pos", 1'b1, 16'h0001, 1'b0);
    tick(1, 32'hFFFF_FFFE, 1);
    chk_lit("rnd_tie_neg", 1'b1, 16'h0000, 1'b0);
    tick(1, 32'h7FFF_FFFF, 1);
    chk_lit("max_nowrap", 1'b1, 16'h4000, 1'b1);
    tick(0, '0, 1);
    chk_lit("drained", 1'b0, '0, 1'b0);

    // Backpressure with three samples offered while yumi_i is held low
    tick(1, 32'h0000_4000, 0);
    tick(1, 32'h0000_8000, 0);
    chk("full_ready", longint'(ready_o), 0);
    tick(1, 32'h0000_C000, 0);
    chk_lit("full_head", 1'b1, 16'h1000, 1'b0);
    tick(1, 32'h0000_C000, 1);
    chk_lit("pop_a", 1'b1, 16'h2000, 1'b0);
    tick(1, 32'h0000_C000, 1);
    chk_lit("pop_b", 1'b1, 16'h3000, 1'b0);
    tick(0, '0, 1);

    // Streaming at occupancy 1: enqueue and dequeue in the same cycle
    tick(1, 32'h0000_0100, 0);
    c0 = m_count;
    for (int i = 0; i < 10; i++) begin
      tick(1, rand_data(), 1);
      chk("stream_v", longint'(v_o), 1);
      chk("stream_ready", longint'(ready_o), 1);
    end
    chk("stream_count", longint'(count_o), longint'((c0 + 10) % (1 << CW)));
    tick(0, '0, 1);

    // Random traffic, including illegal yumi_i while empty
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 9) < 7), rand_data(), ($urandom_range(0, 9) < 6));
    end
    for (int i = 0; i < 3; i++) tick(0, '0, 1);

    // Asynchronous reset pulse between edges with two entries buffered and count 5
    reset_n = 1'b0;
    model_reset();
    #2 reset_n = 1'b1;
    #1 compare();
    tick(0, '0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(1, 32'h0000_4000, 0);
      tick(0, '0, 1);
    end
    tick(1, 32'h0000_8000, 0);
    tick(1, 32'h0000_C000, 0);
    chk("pre_rst_count", longint'(count_o), 5);
    chk("pre_rst_v", longint'(v_o), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_v", longint'(v_o), 0);
    chk("async_count", longint'(count_o), 0);
    chk("async_ready", longint'(ready_o), 0);
    chk("async_data", longint'(data_o), 0);
    chk("async_sat", longint'(sat_o), 0);
    model_reset();
    #1 reset_n = 1'b1;
    #1 compare();
    tick(0, '0, 1);
    chk("post_rst_ready", longint'(ready_o), 1);
    tick(0, '0, 1);
    chk("post_rst_nodeliver", longint'(count_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
